// File: rtl/wb_openram_pkg.sv
// Shared definitions for the banked Wishbone/OpenRAM bridge.
//   DATA_W   : Wishbone and macro data width
//   SEL_W    : byte-select / write-mask width
//   state_e  : bridge FSM states (idle, macro command, read wait, bus response)
//   win_mask : byte-address mask covering the whole banked window
package wb_openram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StWait,
      StResp
   } state_e;

   // Window spans 2**addr_width words of 4 bytes in each of 2**bank_bits banks.
   function automatic logic [31:0] win_mask(input int unsigned addr_width,
                                            input int unsigned bank_bits);
      return (32'd1 << (addr_width + 2 + bank_bits)) - 32'd1;
   endfunction

endpackage

// File: rtl/wb_openram_rdmux.sv
// Read-data select across the macro array.
//   dout_i  : concatenated macro read data, bank k on bits [32k+31:32k]
//   bank_i  : latched bank index
//   rdata_o : selected bank's word (zero for an index with no macro behind it)
module wb_openram_rdmux
   import wb_openram_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned BANK_BITS = 1
) (
   input  logic [NUM_BANKS*DATA_W-1:0] dout_i,
   input  logic [BANK_BITS-1:0]        bank_i,
   output logic [DATA_W-1:0]           rdata_o
);

   always_comb begin
      rdata_o = '0;
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
         if (bank_i == BANK_BITS'(k)) begin
            rdata_o = dout_i[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/wb_openram_banked.sv
// Wishbone classic slave mapping an aligned window onto NUM_BANKS OpenRAM RW macros.
//   wb_clk_i / wb_rst_ni : clock, asynchronous active-low reset
//   wbs_*                : Wishbone slave (stb/cyc/we/sel/adr/dat in, ack/err/dat out)
//   ram_clk0             : macro clock (same net as wb_clk_i)
//   ram_csb0             : per-bank active-low select, low only in the command cycle
//   ram_web0/ram_wmask0  : shared write enable (active-low) and byte mask
//   ram_addr0/ram_din0   : shared word address and write data, held from the request latch
//   ram_dout0            : concatenated macro read data
// Write: hit, command, ack. Read: hit, command, wait, ack. Unpopulated bank: hit, err.
module wb_openram_banked
   import wb_openram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h30c0_0000,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned BANK_BITS  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic                        wbs_stb_i,
   input  logic                        wbs_cyc_i,
   input  logic                        wbs_we_i,
   input  logic [SEL_W-1:0]            wbs_sel_i,
   input  logic [31:0]                 wbs_adr_i,
   input  logic [DATA_W-1:0]           wbs_dat_i,
   output logic                        wbs_ack_o,
   output logic                        wbs_err_o,
   output logic [DATA_W-1:0]           wbs_dat_o,
   output logic                        ram_clk0,
   output logic [NUM_BANKS-1:0]        ram_csb0,
   output logic                        ram_web0,
   output logic [SEL_W-1:0]            ram_wmask0,
   output logic [ADDR_WIDTH-1:0]       ram_addr0,
   output logic [DATA_W-1:0]           ram_din0,
   input  logic [NUM_BANKS*DATA_W-1:0] ram_dout0
);

   localparam logic [31:0] WIN_MASK = win_mask(ADDR_WIDTH, BANK_BITS);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [BANK_BITS-1:0]  bank_q;
   logic                  we_q;
   logic [SEL_W-1:0]      sel_q;
   logic [DATA_W-1:0]     dat_q;
   logic                  err_q;
   logic [DATA_W-1:0]     rdata_q;

   logic                  hit;
   logic                  accept;
   logic [BANK_BITS-1:0]  req_bank;
   logic                  req_bad_bank;
   logic [DATA_W-1:0]     mux_rdata;
   logic                  bus_live;

   assign ram_clk0 = wb_clk_i;

   assign hit          = wbs_stb_i & wbs_cyc_i & ((wbs_adr_i & ~WIN_MASK) == BASE_ADDR);
   assign accept       = (state_q == StIdle) & hit;
   assign req_bank     = wbs_adr_i[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2];
   // Only reachable when NUM_BANKS is not a power of two (or is 1).
   assign req_bad_bank = 32'(req_bank) >= NUM_BANKS;
   assign bus_live     = wbs_cyc_i & wbs_stb_i;

   wb_openram_rdmux #(
      .NUM_BANKS (NUM_BANKS),
      .BANK_BITS (BANK_BITS)
   ) u_rdmux (
      .dout_i  (ram_dout0),
      .bank_i  (bank_q),
      .rdata_o (mux_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (hit) state_d = req_bad_bank ? StResp : StCmd;
         StCmd:   state_d = we_q ? StResp : StWait;
         StWait:  state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= StIdle;
         addr_q  <= '0;
         bank_q  <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         dat_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= wbs_adr_i[ADDR_WIDTH+1:2];
            bank_q <= req_bank;
            we_q   <= wbs_we_i;
            sel_q  <= wbs_sel_i;
            dat_q  <= wbs_dat_i;
            err_q  <= req_bad_bank;
         end
         // The macro drove its word during the wait cycle; take it on the closing edge.
         if (state_q == StWait) begin
            rdata_q <= mux_rdata;
         end
      end
   end

   always_comb begin
      ram_csb0   = '1;
      ram_web0   = 1'b1;
      ram_wmask0 = '0;
      if (state_q == StCmd) begin
         for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == BANK_BITS'(k)) begin
               ram_csb0[k] = 1'b0;
            end
         end
         ram_web0   = ~we_q;
         ram_wmask0 = we_q ? sel_q : '0;
      end
   end

   // Address and data simply follow the request latch, so they hold outside the command.
   assign ram_addr0 = addr_q;
   assign ram_din0  = dat_q;

   // Gating by the live bus suppresses the response of an aborted cycle.
   assign wbs_ack_o = (state_q == StResp) & ~err_q & bus_live;
   assign wbs_err_o = (state_q == StResp) &  err_q & bus_live;
   assign wbs_dat_o = rdata_q;

endmodule
